// File: rtl/alu_cmd_driver.sv
`default_nettype none
// ============================================================================
// Module      : alu_cmd_driver
// Description : Queues (opcode, operand) commands and issues each one to the
//               button-driven ALU as a single one-hot pulse, then returns the
//               captured Ans/flags/error. Optional counters: ALU_DRV_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_cmd_driver #(
  parameter int N          = 16,
  parameter int DEPTH      = 4,
  parameter int EXTRA_WAIT = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [3:0]    cmd_op,
  input  logic [N-1:0]  cmd_data,
  output logic [13:0]   buttons,
  output logic [N-1:0]  alu_bus_in,
  input  logic [N-1:0]  alu_bus_out,
  input  logic [3:0]    alu_flags,
  input  logic [2:0]    alu_error,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [3:0]    rsp_op,
  output logic [N-1:0]  rsp_data,
  output logic [3:0]    rsp_flags,
  output logic [2:0]    rsp_error,
  output logic          rsp_illegal,
  output logic          busy
`ifdef ALU_DRV_STATS_EN
  ,
  output logic [15:0]   done_count,
  output logic [7:0]    err_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int WW = (EXTRA_WAIT > 0) ? $clog2(EXTRA_WAIT + 1) : 1;
  localparam logic [AW:0] c_full = (AW + 1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DRIVE = 3'd1,
    S_HOLD  = 3'd2,
    S_WAITX = 3'd3,
    S_CAPT  = 3'd4,
    S_RESP  = 3'd5
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [3:0]      r_fifo_op   [DEPTH];
  logic [N-1:0]    r_fifo_data [DEPTH];
  logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [AW:0]     r_count;
  logic [3:0]      r_op;
  logic [N-1:0]    r_data;
  logic            r_illegal;
  logic [N-1:0]    r_rsp_data;
  logic [3:0]      r_rsp_flags;
  logic [2:0]      r_rsp_error;
  logic [WW-1:0]   r_wait;
  logic            w_push, w_pop, w_head_legal;
  logic [3:0]      w_head_op;
  logic [2:0]      w_err_mask;

  assign cmd_ready    = (r_count != c_full);
  assign w_push       = cmd_valid & cmd_ready;
  assign w_pop        = (r_state == S_IDLE) & (r_count != '0);
  assign w_head_op    = r_fifo_op[r_rd_ptr];
  assign w_head_legal = (w_head_op != 4'd0) & (w_head_op != 4'd15);

  assign rsp_valid    = (r_state == S_RESP);
  assign rsp_op       = r_op;
  assign rsp_data     = r_rsp_data;
  assign rsp_flags    = r_rsp_flags;
  assign rsp_error    = r_rsp_error;
  assign rsp_illegal  = r_illegal;
  assign busy         = (r_state != S_IDLE) | (r_count != '0);

  // Storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_op[r_wr_ptr]   <= cmd_op;
      r_fifo_data[r_wr_ptr] <= cmd_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Only the arithmetic ops own an error bit; everything else reports none.
  always_comb begin
    w_err_mask = 3'b000;
    case (r_op)
      4'd1:    w_err_mask = 3'b100;
      4'd2:    w_err_mask = 3'b010;
      4'd3:    w_err_mask = 3'b001;
      default: w_err_mask = 3'b000;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    buttons     = '0;
    alu_bus_in  = '0;
    case (r_state)
      S_IDLE: begin
        if (w_pop) w_state_nxt = w_head_legal ? S_DRIVE : S_RESP;
      end
      S_DRIVE: begin
        buttons     = 14'(1) << (r_op - 4'd1);
        alu_bus_in  = r_data;
        w_state_nxt = S_HOLD;
      end
      S_HOLD: begin
        alu_bus_in  = r_data;
        w_state_nxt = (EXTRA_WAIT > 0) ? S_WAITX : S_CAPT;
      end
      S_WAITX: begin
        alu_bus_in = r_data;
        if (r_wait == WW'(EXTRA_WAIT - 1)) w_state_nxt = S_CAPT;
      end
      S_CAPT: w_state_nxt = S_RESP;
      S_RESP: begin
        if (rsp_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op        <= '0;
      r_data      <= '0;
      r_illegal   <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_flags <= '0;
      r_rsp_error <= '0;
      r_wait      <= '0;
    end else begin
      if (w_pop) begin
        r_op      <= w_head_op;
        r_data    <= r_fifo_data[r_rd_ptr];
        r_illegal <= ~w_head_legal;
        if (!w_head_legal) r_rsp_error <= 3'b000;
      end
      // Error is only meaningful while the ALU still holds the op.
      if (r_state == S_HOLD) begin
        r_rsp_error <= alu_error & w_err_mask;
        r_wait      <= '0;
      end
      if (r_state == S_WAITX) r_wait <= r_wait + 1'b1;
      if (r_state == S_CAPT) begin
        r_rsp_data  <= alu_bus_out;
        r_rsp_flags <= alu_flags;
      end
    end
  end

`ifdef ALU_DRV_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_count <= '0;
      err_count  <= '0;
    end else if (rsp_valid && rsp_ready) begin
      if (!r_illegal) done_count <= done_count + 1'b1;
      if ((|r_rsp_error) && (err_count != 8'hFF)) err_count <= err_count + 1'b1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_cmd_driver
// Description : Directed vector bench for alu_cmd_driver with a behavioural
//               two-edge button ALU.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_cmd_driver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  cmd_op = 4'd0;
  logic [15:0] cmd_data = 16'd0;
  logic [13:0] buttons;
  logic [15:0] alu_bus_in;
  logic [15:0] alu_bus_out;
  logic [3:0]  alu_flags;
  logic [2:0]  alu_error;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [3:0]  rsp_op;
  logic [15:0] rsp_data;
  logic [3:0]  rsp_flags;
  logic [2:0]  rsp_error;
  logic        rsp_illegal;
  logic        busy;
`ifdef ALU_DRV_STATS_EN
  logic [15:0] done_count;
  logic [7:0]  err_count;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_cmd_driver #(.N(16), .DEPTH(4), .EXTRA_WAIT(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .buttons(buttons), .alu_bus_in(alu_bus_in), .alu_bus_out(alu_bus_out),
    .alu_flags(alu_flags), .alu_error(alu_error),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_op(rsp_op), .rsp_data(rsp_data),
    .rsp_flags(rsp_flags), .rsp_error(rsp_error), .rsp_illegal(rsp_illegal), .busy(busy)
`ifdef ALU_DRV_STATS_EN
    , .done_count(done_count), .err_count(err_count)
`endif
  );

  // Behavioural ALU: edge 1 latches the button and busIn, edge 2 executes.
  logic [15:0] m_a = '0, m_b = '0, m_ans = '0, m_dr = '0;
  logic [13:0] m_opr = '0;
  logic [15:0] m_sum, m_diff;
  logic [31:0] m_prod;

  always @(posedge clk) begin
    m_opr <= buttons;
    m_dr  <= alu_bus_in;
    case (m_opr)
      14'h0001: m_ans <= m_a + m_b;
      14'h0002: m_ans <= m_a - m_b;
      14'h0004: m_ans <= m_a * m_b;
      14'h0008: m_ans <= m_a & m_b;
      14'h0010: m_ans <= m_a | m_b;
      14'h0020: m_ans <= ~m_a;
      14'h0040: m_ans <= m_a ^ m_b;
      14'h0080: m_a   <= m_dr;
      14'h0100: m_b   <= m_dr;
      14'h0200: m_a   <= m_ans;
      14'h0400: m_b   <= m_ans;
      14'h0800: begin m_a <= '0; m_b <= '0; m_ans <= '0; end
      14'h1000: m_ans <= m_a;
      14'h2000: m_ans <= m_b;
      default: ;
    endcase
  end

  assign m_sum       = m_a + m_b;
  assign m_diff      = m_a - m_b;
  assign m_prod      = {16'd0, m_a} * {16'd0, m_b};
  assign alu_bus_out = m_ans;
  assign alu_flags   = {m_ans[15], $signed(m_a) > $signed(m_b), m_a == m_b, $signed(m_a) < $signed(m_b)};
  // Raw error reports every condition regardless of op, so masking is exercised.
  assign alu_error   = (m_opr == '0) ? 3'b000 :
                       {(m_a[15] == m_b[15]) && (m_sum[15] != m_a[15]),
                        (m_a[15] != m_b[15]) && (m_diff[15] != m_a[15]),
                        m_prod[31:16] != 16'd0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Buttons must be one-hot and never high on consecutive cycles.
  logic [13:0] prev_btn = '0;
  always @(negedge clk) begin
    if (buttons != '0) begin
      n_assert++;
      if ($countones(buttons) != 1 || prev_btn != '0) begin
        n_fail++;
        $display("FAIL button_pulse: got %0h after %0h expected single one-hot", buttons, prev_btn);
      end
    end
    prev_btn = buttons;
  end

  typedef struct {
    logic [3:0]  op;
    logic [15:0] data;
    logic [15:0] exp_data;
    logic [3:0]  exp_flags;
    logic [2:0]  exp_err;
    logic        exp_ill;
    logic [13:0] exp_btn;
  } vec_t;

  vec_t vecs  [22];
  vec_t svecs [9];

  task automatic run_vec(input vec_t v, input string tag);
    int lat, bcnt, w;
    logic [13:0] bor;
    lat = -1; bcnt = 0; bor = '0; w = 0;
    @(negedge clk);
    cmd_op = v.op; cmd_data = v.data; cmd_valid = 1'b1;
    while (!cmd_ready && w < 50) begin @(negedge clk); w++; end
    chk($sformatf("%s accept", tag), {31'd0, cmd_ready}, 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (buttons != '0) begin bor |= buttons; bcnt++; end
      if (rsp_valid) begin lat = n; break; end
      @(negedge clk);
    end
    chk($sformatf("%s latency", tag), 32'(lat), v.exp_ill ? 32'd1 : 32'd4);
    chk($sformatf("%s op", tag), {28'd0, rsp_op}, {28'd0, v.op});
    chk($sformatf("%s data", tag), {16'd0, rsp_data}, {16'd0, v.exp_data});
    chk($sformatf("%s flags", tag), {28'd0, rsp_flags}, {28'd0, v.exp_flags});
    chk($sformatf("%s error", tag), {29'd0, rsp_error}, {29'd0, v.exp_err});
    chk($sformatf("%s illegal", tag), {31'd0, rsp_illegal}, {31'd0, v.exp_ill});
    chk($sformatf("%s buttons", tag), {18'd0, bor}, {18'd0, v.exp_btn});
    chk($sformatf("%s pulses", tag), 32'(bcnt), v.exp_ill ? 32'd0 : 32'd1);
    chk($sformatf("%s busin_resp", tag), {16'd0, alu_bus_in}, 32'd0);
    @(negedge clk);
  endtask

  logic [3:0]  bops [6];
  logic [15:0] bdat [6];
  logic [15:0] bexp [6];

  initial begin
    int pi, ri, w;
    vecs[0]  = '{4'd12, 16'hABCD, 16'h0000, 4'b0010, 3'b000, 1'b0, 14'h0800};
    vecs[1]  = '{4'd8,  16'h0005, 16'h0000, 4'b0100, 3'b000, 1'b0, 14'h0080};
    vecs[2]  = '{4'd9,  16'h0003, 16'h0000, 4'b0100, 3'b000, 1'b0, 14'h0100};
    vecs[3]  = '{4'd1,  16'hABCD, 16'h0008, 4'b0100, 3'b000, 1'b0, 14'h0001};
    vecs[4]  = '{4'd8,  16'h7FFF, 16'h0008, 4'b0100, 3'b000, 1'b0, 14'h0080};
    vecs[5]  = '{4'd9,  16'h0002, 16'h0008, 4'b0100, 3'b000, 1'b0, 14'h0100};
    vecs[6]  = '{4'd1,  16'hABCD, 16'h8001, 4'b1100, 3'b100, 1'b0, 14'h0001};
    vecs[7]  = '{4'd8,  16'h8000, 16'h8001, 4'b1001, 3'b000, 1'b0, 14'h0080};
    vecs[8]  = '{4'd9,  16'h0001, 16'h8001, 4'b1001, 3'b000, 1'b0, 14'h0100};
    vecs[9]  = '{4'd2,  16'hABCD, 16'h7FFF, 4'b0001, 3'b010, 1'b0, 14'h0002};
    vecs[10] = '{4'd9,  16'h0004, 16'h7FFF, 4'b0001, 3'b000, 1'b0, 14'h0100};
    vecs[11] = '{4'd3,  16'hABCD, 16'h0000, 4'b0001, 3'b001, 1'b0, 14'h0004};
    vecs[12] = '{4'd4,  16'hABCD, 16'h0000, 4'b0001, 3'b000, 1'b0, 14'h0008};
    vecs[13] = '{4'd5,  16'hABCD, 16'h8004, 4'b1001, 3'b000, 1'b0, 14'h0010};
    vecs[14] = '{4'd7,  16'hABCD, 16'h8004, 4'b1001, 3'b000, 1'b0, 14'h0040};
    vecs[15] = '{4'd6,  16'hABCD, 16'h7FFF, 4'b0001, 3'b000, 1'b0, 14'h0020};
    vecs[16] = '{4'd10, 16'hABCD, 16'h7FFF, 4'b0100, 3'b000, 1'b0, 14'h0200};
    vecs[17] = '{4'd14, 16'hABCD, 16'h0004, 4'b0100, 3'b000, 1'b0, 14'h2000};
    vecs[18] = '{4'd11, 16'hABCD, 16'h0004, 4'b0100, 3'b000, 1'b0, 14'h0400};
    vecs[19] = '{4'd13, 16'hABCD, 16'h7FFF, 4'b0100, 3'b000, 1'b0, 14'h1000};
    vecs[20] = '{4'd0,  16'h1111, 16'h7FFF, 4'b0100, 3'b000, 1'b1, 14'h0000};
    vecs[21] = '{4'd15, 16'h2222, 16'h7FFF, 4'b0100, 3'b000, 1'b1, 14'h0000};

    svecs[0] = '{4'd8,  16'h7FFF, 16'h0000, 4'b0100, 3'b000, 1'b0, 14'h0080};
    svecs[1] = '{4'd9,  16'h0002, 16'h0000, 4'b0100, 3'b000, 1'b0, 14'h0100};
    svecs[2] = '{4'd1,  16'hABCD, 16'h8001, 4'b1100, 3'b100, 1'b0, 14'h0001};
    svecs[3] = '{4'd8,  16'h7FFF, 16'h8001, 4'b1100, 3'b000, 1'b0, 14'h0080};
    svecs[4] = '{4'd9,  16'h0002, 16'h8001, 4'b1100, 3'b000, 1'b0, 14'h0100};
    svecs[5] = '{4'd1,  16'hABCD, 16'h8001, 4'b1100, 3'b100, 1'b0, 14'h0001};
    svecs[6] = '{4'd8,  16'hF0F0, 16'h8001, 4'b1001, 3'b000, 1'b0, 14'h0080};
    svecs[7] = '{4'd9,  16'h0FF0, 16'h8001, 4'b1001, 3'b000, 1'b0, 14'h0100};
    svecs[8] = '{4'd4,  16'hABCD, 16'h00F0, 4'b0001, 3'b000, 1'b0, 14'h0008};

    bops = '{4'd12, 4'd8, 4'd9, 4'd13, 4'd14, 4'd11};
    bdat = '{16'h0, 16'h1111, 16'h2222, 16'h0, 16'h0, 16'h0};
    bexp = '{16'h0, 16'h0, 16'h0, 16'h1111, 16'h2222, 16'h2222};

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst buttons", {18'd0, buttons}, 32'd0);
    chk("rst busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post-rst busin", {16'd0, alu_bus_in}, 32'd0);
    chk("post-rst rsp_data", {16'd0, rsp_data}, 32'd0);

    for (int i = 0; i < 22; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Back-to-back pushes while responses are stalled
    pi = 0; ri = 0;
    rsp_ready = 1'b0;
    for (int cyc = 0; cyc < 200 && ri < 6; cyc++) begin
      @(negedge clk);
      if (cyc == 12) begin
        chk("b2b accepted", 32'(pi), 32'd5);
        chk("b2b full ready", {31'd0, cmd_ready}, 32'd0);
        chk("b2b busy", {31'd0, busy}, 32'd1);
        rsp_ready = 1'b1;
      end
      if (rsp_valid && rsp_ready) begin
        chk($sformatf("b2b%0d op", ri), {28'd0, rsp_op}, {28'd0, bops[ri]});
        chk($sformatf("b2b%0d data", ri), {16'd0, rsp_data}, {16'd0, bexp[ri]});
        ri++;
      end
      if (pi < 6) begin
        cmd_valid = 1'b1; cmd_op = bops[pi]; cmd_data = bdat[pi];
      end else begin
        cmd_valid = 1'b0;
      end
      if (cmd_valid && cmd_ready) pi++;
    end
    cmd_valid = 1'b0;
    chk("b2b responses", 32'(ri), 32'd6);
    @(negedge clk);

    // Asynchronous reset while the FSM sits in HOLD
    cmd_op = 4'd8; cmd_data = 16'h1234; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    w = 0;
    while (buttons == '0 && w < 20) begin @(negedge clk); w++; end
    chk("hold drive seen", {18'd0, buttons}, 32'h0080);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst buttons", {18'd0, buttons}, 32'd0);
    chk("arst busin", {16'd0, alu_bus_in}, 32'd0);
    chk("arst rsp_data", {16'd0, rsp_data}, 32'd0);
    chk("arst rsp_op", {28'd0, rsp_op}, 32'd0);
    chk("arst cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("arst busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(vecs[0], "clr_after_rst");

    // Counter run from a fresh reset
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++) run_vec(svecs[i], $sformatf("s%0d", i));
`ifdef ALU_DRV_STATS_EN
    chk("done_count", {16'd0, done_count}, 32'd9);
    chk("err_count", {24'd0, err_count}, 32'd2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
